// File: rtl/ranging_pkg.sv
// Shared pixel type and kernel-size bounds for the ranging kernel sorter.
package ranging_pkg;
  localparam int PIXEL_WIDTH     = 8;
  localparam int KERNEL_SIZE_MIN = 2;
  localparam int KERNEL_SIZE_MAX = 9;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
endpackage

// File: rtl/ranging_kernel_nxn_if.sv
// Beat bus for the NxN ranging kernel: window in, sorted window out.
interface ranging_kernel_nxn_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3
);
  // A beat moves on a rising edge where valid and ready are both 1; the
  // sender holds payload and valid steady until that edge, and ready may
  // depend combinationally on the receiver's own output valid.
  logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] i_kernel;
  logic                                                    i_sort_by_column;
  logic                                                    i_valid;
  logic                                                    o_ready;
  logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] o_kernel_sorted;
  logic                                                    o_sort_by_column;
  logic                                                    o_valid;
  logic                                                    i_ready;

  modport master (
    output i_kernel, i_sort_by_column, i_valid, i_ready,
    input  o_ready, o_kernel_sorted, o_sort_by_column, o_valid
  );

  modport slave (
    input  i_kernel, i_sort_by_column, i_valid, i_ready,
    output o_ready, o_kernel_sorted, o_sort_by_column, o_valid
  );
endinterface

// File: rtl/compare_swap_stage.sv
// One registered odd-even transposition phase over a single line of K pixels.
module compare_swap_stage #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int PHASE       = 0
) (
  input  logic                                   i_clk,
  input  logic                                   i_aresetn,
  input  logic                                   i_advance,
  input  logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] i_line,
  output logic [0:KERNEL_SIZE-1][DATA_WIDTH-1:0] o_line
);
  localparam int K = KERNEL_SIZE;

  logic [0:K-1][DATA_WIDTH-1:0] line_d, line_q;

  // Pairs start at PHASE; the lower slot takes the min, the upper the max,
  // so equal values stay where they are.
  for (genvar j = 0; j < K; j++) begin : g_elem
    if (j >= PHASE && (j - PHASE) % 2 == 0 && j + 1 < K) begin : g_lo
      assign line_d[j] = (i_line[j] > i_line[j+1]) ? i_line[j+1] : i_line[j];
    end else if (j >= PHASE + 1 && (j - PHASE - 1) % 2 == 0) begin : g_hi
      assign line_d[j] = (i_line[j-1] > i_line[j]) ? i_line[j-1] : i_line[j];
    end else begin : g_pass
      assign line_d[j] = i_line[j];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      line_q <= '0;
    end else if (i_advance) begin
      line_q <= line_d;
    end
  end

  assign o_line = line_q;
endmodule

// File: rtl/ranging_kernel_nxn.sv
// Sorts every line or every column of a KxK window through a K-stage
// odd-even transposition pipeline with valid/ready flow control.
module ranging_kernel_nxn
  import ranging_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3
) (
  input logic                 i_clk,
  input logic                 i_aresetn,
  ranging_kernel_nxn_if.slave bus
);
  localparam int K = KERNEL_SIZE;

  if (K < KERNEL_SIZE_MIN || K > KERNEL_SIZE_MAX) begin : g_bad_kernel_size
    $fatal(1, "ranging_kernel_nxn: KERNEL_SIZE must be within 2..9");
  end

  typedef logic [0:K-1][0:K-1][DATA_WIDTH-1:0] win_t;

  win_t         net [0:K];
  win_t         in_t, out_t;
  logic         advance;
  logic [0:K-1] valid_d, valid_q;
  logic [0:K-1] mode_d, mode_q;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign advance     = !bus.o_valid || bus.i_ready;
  assign bus.o_ready = advance;

  // Column mode runs the network on the transposed window.
  always_comb begin
    in_t  = '0;
    out_t = '0;
    for (int l = 0; l < K; l++) begin
      for (int c = 0; c < K; c++) begin
        in_t[l][c]  = bus.i_kernel[c][l];
        out_t[l][c] = net[K][c][l];
      end
    end
  end

  assign net[0] = bus.i_sort_by_column ? in_t : bus.i_kernel;

  for (genvar s = 0; s < K; s++) begin : g_stage
    for (genvar l = 0; l < K; l++) begin : g_line
      compare_swap_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .KERNEL_SIZE(K),
        .PHASE      (s % 2)
      ) u_cs (
        .i_clk    (i_clk),
        .i_aresetn(i_aresetn),
        .i_advance(advance),
        .i_line   (net[s][l]),
        .o_line   (net[s+1][l])
      );
    end
  end

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    if (advance) begin
      valid_d = {bus.i_valid, valid_q[0:K-2]};
      mode_d  = {bus.i_sort_by_column, mode_q[0:K-2]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      valid_q <= '0;
      mode_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.o_valid          = valid_q[K-1];
  assign bus.o_sort_by_column = mode_q[K-1];
  assign bus.o_kernel_sorted  = mode_q[K-1] ? out_t : net[K];
endmodule

// File: tb/tb_ranging_kernel_nxn.sv
// Directed and random checks of the ranging kernel sorter at K=3 and K=5.
module tb_ranging_kernel_nxn;
  import ranging_pkg::*;

  typedef pixel_t [0:2][0:2] win3_t;
  typedef pixel_t [0:4][0:4] win5_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ranging_kernel_nxn_if #(.DATA_WIDTH(8), .KERNEL_SIZE(3)) if3 ();
  ranging_kernel_nxn_if #(.DATA_WIDTH(8), .KERNEL_SIZE(5)) if5 ();

  ranging_kernel_nxn #(.DATA_WIDTH(8), .KERNEL_SIZE(3)) u_dut3 (
    .i_clk(clk), .i_aresetn(rst_n), .bus(if3)
  );
  ranging_kernel_nxn #(.DATA_WIDTH(8), .KERNEL_SIZE(5)) u_dut5 (
    .i_clk(clk), .i_aresetn(rst_n), .bus(if5)
  );

  int checks = 0;
  int errors = 0;

  logic [72:0]  exp3_q[$];
  logic [200:0] exp5_q[$];
  int           out5_cyc[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic win5_t model_sort(input win5_t w, input logic by_col, input int k);
    win5_t  r = w;
    pixel_t a, b;
    for (int x = 0; x < k; x++)
      for (int p = 0; p < k - 1; p++)
        for (int i = 0; i < k - 1 - p; i++) begin
          if (by_col) begin
            a = r[i][x]; b = r[i+1][x];
            if (a > b) begin r[i][x] = b; r[i+1][x] = a; end
          end else begin
            a = r[x][i]; b = r[x][i+1];
            if (a > b) begin r[x][i] = b; r[x][i+1] = a; end
          end
        end
    return r;
  endfunction

  function automatic win5_t to5(input win3_t w);
    win5_t r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) r[i][j] = w[i][j];
    return r;
  endfunction

  function automatic win3_t from5(input win5_t w);
    win3_t r;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) r[i][j] = w[i][j];
    return r;
  endfunction

  function automatic win5_t rand_win5();
    win5_t r;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) r[i][j] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  function automatic logic [72:0] exp3_of(input win3_t w, input logic m);
    return {m, from5(model_sort(to5(w), m, 3))};
  endfunction

  // ---------------- driver ----------------
  task automatic drive3(input win3_t w, input logic m, input logic [72:0] e);
    @(negedge clk);
    if3.i_kernel         = w;
    if3.i_sort_by_column = m;
    if3.i_valid          = 1'b1;
    exp3_q.push_back(e);
    @(posedge clk);
  endtask

  // ---------------- scoreboard ----------------
  always begin
    @(negedge clk); #1;
    if (if3.o_valid && if3.i_ready) begin
      checks++;
      assert (exp3_q.size() > 0) else begin
        errors++;
        $error("FAIL out3_unexpected observed=%0h expected=none", if3.o_kernel_sorted);
      end
      if (exp3_q.size() > 0)
        chk("out3", {if3.o_sort_by_column, if3.o_kernel_sorted}, exp3_q.pop_front());
    end
  end

  always begin
    @(negedge clk); #1;
    if (if5.o_valid && if5.i_ready) begin
      checks++;
      assert (exp5_q.size() > 0) else begin
        errors++;
        $error("FAIL out5_unexpected observed=%0h expected=none", if5.o_kernel_sorted);
      end
      if (exp5_q.size() > 0) begin
        chk("out5", {if5.o_sort_by_column, if5.o_kernel_sorted}, exp5_q.pop_front());
        out5_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  win3_t       wa, weq, wx, w3;
  win5_t       w5;
  logic [72:0] ea, eb, ex0, ex1;
  int          first5;

  initial begin
    wa  = {8'd9, 8'd1, 8'd5, 8'd3, 8'd3, 8'd0, 8'd255, 8'd0, 8'd128};
    ea  = {1'b0, 8'd1, 8'd5, 8'd9, 8'd0, 8'd3, 8'd3, 8'd0, 8'd128, 8'd255};
    eb  = {1'b1, 8'd3, 8'd0, 8'd0, 8'd9, 8'd1, 8'd5, 8'd255, 8'd3, 8'd128};
    weq = {9{8'h7F}};
    wx  = {8'hFF, 8'h00, 8'h80, 8'h00, 8'hFF, 8'h01, 8'h7F, 8'hFF, 8'h00};
    ex0 = {1'b0, 8'h00, 8'h80, 8'hFF, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h7F, 8'hFF};
    ex1 = {1'b1, 8'h00, 8'h00, 8'h00, 8'h7F, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'h80};

    // A beat offered during reset must be discarded.
    rst_n = 1'b0;
    if3.i_kernel = wa; if3.i_sort_by_column = 1'b0; if3.i_valid = 1'b1; if3.i_ready = 1'b1;
    if5.i_kernel = '0; if5.i_sort_by_column = 1'b0; if5.i_valid = 1'b0; if5.i_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid3", if3.o_valid, 1'b0);
    chk("rst_data3", if3.o_kernel_sorted, '0);
    chk("rst_mode3", if3.o_sort_by_column, 1'b0);
    chk("rst_ready3", if3.o_ready, 1'b1);
    chk("rst_valid5", if5.o_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; if3.i_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Line then column mode on the same window, back to back, with latency.
    drive3(wa, 1'b0, ea);
    drive3(wa, 1'b1, eb);
    @(negedge clk); if3.i_valid = 1'b0; #1;
    chk("lat_early", if3.o_valid, 1'b0);
    @(negedge clk); #1;
    chk("lat_k", if3.o_valid, 1'b1);

    // Equal pixels and unsigned extremes.
    drive3(weq, 1'b0, {1'b0, weq});
    drive3(weq, 1'b1, {1'b1, weq});
    drive3(wx, 1'b0, ex0);
    drive3(wx, 1'b1, ex1);
    @(negedge clk); if3.i_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("drain_a", exp3_q.size(), 0);

    // K=5 streaming, alternating mode.
    first5 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      w5 = rand_win5();
      if5.i_kernel = w5; if5.i_sort_by_column = i[0]; if5.i_valid = 1'b1;
      exp5_q.push_back({i[0], model_sort(w5, i[0], 5)});
      if (i == 0) first5 = cyc;
    end
    @(negedge clk); if5.i_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("k5_count", out5_cyc.size(), 20);
    if (out5_cyc.size() > 0) chk("k5_first_latency", out5_cyc[0] - first5, 5);
    for (int i = 1; i < out5_cyc.size(); i++) chk("k5_rate", out5_cyc[i] - out5_cyc[i-1], 1);
    chk("drain5", exp5_q.size(), 0);

    // Fill the K=3 pipe, then stall the output for 6 cycles.
    for (int i = 0; i < 5; i++) begin
      w3 = from5(rand_win5());
      drive3(w3, i[0], exp3_of(w3, i[0]));
    end
    @(negedge clk);
    w3 = from5(rand_win5());
    if3.i_kernel = w3; if3.i_sort_by_column = 1'b0; if3.i_valid = 1'b1; if3.i_ready = 1'b0;
    exp3_q.push_back(exp3_of(w3, 1'b0));
    for (int r = 0; r < 6; r++) begin
      #1;
      chk("stall_ready", if3.o_ready, 1'b0);
      chk("stall_valid", if3.o_valid, 1'b1);
      chk("stall_hold", {if3.o_sort_by_column, if3.o_kernel_sorted}, exp3_q[0]);
      @(negedge clk);
    end
    if3.i_ready = 1'b1;
    @(negedge clk); if3.i_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("drain_b", exp3_q.size(), 0);

    // Reset with two beats in flight: they must vanish.
    w3 = from5(rand_win5());
    drive3(w3, 1'b1, exp3_of(w3, 1'b1));
    w3 = from5(rand_win5());
    drive3(w3, 1'b0, exp3_of(w3, 1'b0));
    @(negedge clk);
    if3.i_valid = 1'b0; rst_n = 1'b0;
    exp3_q.delete();
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("mid_rst_valid", if3.o_valid, 1'b0);
    chk("mid_rst_data", if3.o_kernel_sorted, '0);
    chk("mid_rst_mode", if3.o_sort_by_column, 1'b0);
    repeat (5) @(negedge clk);

    // First beat after reset emerges after K cycles.
    w3 = from5(rand_win5());
    drive3(w3, 1'b1, exp3_of(w3, 1'b1));
    @(negedge clk); if3.i_valid = 1'b0; #1;
    chk("post_rst_early1", if3.o_valid, 1'b0);
    @(negedge clk); #1;
    chk("post_rst_early2", if3.o_valid, 1'b0);
    @(negedge clk); #1;
    chk("post_rst_k", if3.o_valid, 1'b1);
    repeat (3) @(negedge clk);
    chk("drain_c", exp3_q.size(), 0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
